alu_div_seq: RTL and testbench
==============================

Name: alu_div_seq

Overview:
Multi-cycle sequencer for the ALU's DIV/MOD path. It replaces the single-cycle combinational divide with a radix-2 restoring divider that runs one quotient bit per clock, under a start/busy/done handshake.
- The decode/execute stage issues DIV, DIVU and MOD operations to it and stalls while busy is high.
- It then takes valE and alucc from this block instead of from the combinational ALU result.
- Flag encoding {N, Z, C, V} matches the rest of the ALU.

Parameters:
- WIDTH, 32, operand and result width; the iteration count equals WIDTH.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  issue request; sampled only when busy=0.
- valA  in  WIDTH  dividend.
- valB  in  WIDTH  divisor.
- issigned  in  1  1 = signed (DIV/MOD), 0 = unsigned (DIVU/MODU).
- ismod  in  1  1 = return remainder, 0 = return quotient.
- busy  out  1  high from the edge after start is accepted until done.
- done  out  1  one-cycle pulse: valE and alucc are valid and newly updated.
- valE  out  WIDTH  registered result; holds its value until the next done.
- alucc  out  4  registered flags {N, Z, C, V}; holds its value until the next done.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; busy=0, done=0, valE=0, alucc=0; counter and working registers cleared. A reset mid-operation abandons the operation and produces no done.
- FSM states: IDLE, CALC, FIX.
- IDLE, start=1 at an edge:
  - Latch |valA| and |valB|; two's-complement negate only when issigned=1 and the MSB is set.
  - Latch the sign of the quotient (signA^signB), the sign of the remainder (signA), issigned and ismod.
  - If valB==0 or (issigned and valA==0x8000_0000 and valB==0xFFFF_FFFF): set the special flag and go to FIX. Otherwise clear rem, set cnt=0 and go to CALC.
  - busy=1 from that edge onward.
- CALC: each edge performs one restoring step:
  - {rem, quo} shifted left by 1.
  - trial = rem - divisor.
  - If trial is non-negative: rem=trial and quo[0]=1.
  - cnt++. After WIDTH steps (cnt==WIDTH-1 at the edge), go to FIX.
- FIX (one edge): apply the signs, select the result, write valE/alucc, pulse done=1 for exactly one cycle, clear busy and return to IDLE.
- Latency:
  - Normal case: done is high in the cycle after edge WIDTH+2, counting the start-sampling edge as edge 1 (34 edges for WIDTH=32).
  - Special case: done after 2 edges.
- Normal results:
  - Quotient truncates toward zero; negated when the quotient sign is set.
  - Remainder takes the sign of the dividend; negated when the remainder sign is set.
  - valE = remainder if ismod, else quotient.
- Divide by zero: quotient=all ones, remainder=valA; C=1.
- Signed overflow (INT_MIN / -1): quotient=0x8000_0000, remainder=0; V=1 when ismod=0, V=0 for MOD.
- Flags:
  - N=valE[WIDTH-1]; Z=~|valE.
  - C=divide-by-zero.
  - V=signed overflow on DIV only; V=0 for DIVU and MOD.
- Start handshake:
  - start while busy=1 is ignored: no queueing and no effect on the current operation.
  - start in the same cycle as done (busy still 1) is ignored. The issuer must wait for busy=0, which is the cycle after done.
- Input stability: operands are latched at acceptance, so valA/valB/issigned/ismod may change while busy.

Decomposition:
- Shared package alu_pkg:
  - aluop encodings (ALUOP_DIV=4'b0011, ALUOP_MOD=4'b0100).
  - Flag bit indices (CC_N=3, CC_Z=2, CC_C=1, CC_V=0).
  - FSM state enum div_state_t {IDLE, CALC, FIX}.
- Sub-module div_step: purely combinational single restoring iteration. Inputs rem, quo, divisor; outputs next rem and next quo. Instantiated once.
- FSM, counter, sign handling and output registers live in alu_div_seq.

Test Plan:
1. Unsigned 100/7 (issigned=0, ismod=0): done in the cycle after edge 34; valE=14, alucc=4'b0000. Repeat with ismod=1: valE=2.
2. Signed -7/2: quotient valE=0xFFFF_FFFD, alucc=4'b1000. With ismod=1: valE=0xFFFF_FFFF, alucc=4'b1000. Signed 7/-2, ismod=1: valE=1, alucc=4'b0000.
3. Divide by zero 5/0, unsigned quotient: done after 2 edges; valE=0xFFFF_FFFF, alucc=4'b1010. With ismod=1: valE=5, alucc=4'b0010.
4. Signed 0x8000_0000 / 0xFFFF_FFFF: done after 2 edges; valE=0x8000_0000, alucc=4'b1001. With ismod=1: valE=0, alucc=4'b0100.
5. Extra starts:
   - Pulse start with 9/3 at edge 10 of an in-flight 100/7: first result is still 14.
   - Exactly one done is produced.
   - A start in the cycle after done is accepted and yields 3.
6. Reset mid-operation: assert rst at iteration 10.
   - busy=0, valE=0, alucc=0 immediately, with no clock needed; no done follows.
   - After release, 0xFFFF_FFFF/1 unsigned yields valE=0xFFFF_FFFF, alucc=4'b1000.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: aluop encodings for the divide path, condition-code
// bit positions inside alucc {N, Z, C, V}, and the divider sequencer states.
package alu_pkg;

   localparam logic [3:0] ALUOP_DIV = 4'b0011;
   localparam logic [3:0] ALUOP_MOD = 4'b0100;

   localparam int CC_N = 3;
   localparam int CC_Z = 2;
   localparam int CC_C = 1;
   localparam int CC_V = 0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } div_state_t;

endpackage

// File: rtl/alu_div_seq_div_step.sv
// One radix-2 restoring division iteration, purely combinational.
//   rem, quo   : current partial remainder and quotient/dividend shift register
//   divisor    : magnitude of the divisor
//   rem_n,quo_n: values after shifting {rem,quo} left and trying a subtract
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] quo,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_n,
   output logic [WIDTH-1:0] quo_n
);

   // The shifted remainder can need WIDTH+1 bits when the divisor is large,
   // and the trial carries one more bit so its MSB is a clean borrow.
   logic [WIDTH:0]   sh;
   logic [WIDTH+1:0] trial;

   always_comb begin
      sh    = {rem, quo[WIDTH-1]};
      trial = {1'b0, sh} - {2'b00, divisor};
      if (!trial[WIDTH+1]) begin
         rem_n = trial[WIDTH-1:0];
         quo_n = {quo[WIDTH-2:0], 1'b1};
      end else begin
         // No borrow failed means sh < divisor, so it fits in WIDTH bits.
         rem_n = sh[WIDTH-1:0];
         quo_n = {quo[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/alu_div_seq.sv
// Multi-cycle DIV/DIVU/MOD/MODU unit: restoring divider, one quotient bit per
// clock, with a start/busy/done handshake.
//   clk, rst         : clock, asynchronous active-high reset
//   start            : issue request, accepted only when idle and busy=0
//   valA, valB       : dividend, divisor (latched at acceptance)
//   issigned, ismod  : signed operation, return remainder instead of quotient
//   busy             : operation in flight (stays high through the done cycle)
//   done             : one-cycle pulse, valE/alucc newly updated
//   valE, alucc      : registered result and flags {N, Z, C, V}
module alu_div_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] valA,
   input  logic [WIDTH-1:0] valB,
   input  logic             issigned,
   input  logic             ismod,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] valE,
   output logic [3:0]       alucc
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
   localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

   div_state_t       state, state_n;
   logic [WIDTH-1:0] rem, quo, divisor;
   logic [WIDTH-1:0] rem_n, quo_n;
   logic [CNT_W-1:0] cnt;
   logic             qsign, rsign, mod_r, dz, ovf;

   logic             accept, a_neg, b_neg, dz_in, ovf_in;
   logic [WIDTH-1:0] abs_a, abs_b, q_res, r_res, res;

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem     (rem),
      .quo     (quo),
      .divisor (divisor),
      .rem_n   (rem_n),
      .quo_n   (quo_n)
   );

   always_comb begin
      a_neg  = issigned & valA[WIDTH-1];
      b_neg  = issigned & valB[WIDTH-1];
      abs_a  = a_neg ? -valA : valA;
      abs_b  = b_neg ? -valB : valB;
      dz_in  = (valB == '0);
      ovf_in = issigned && (valA == INT_MIN) && (valB == '1);
   end

   // busy is still high in the done cycle, so a start there is not accepted.
   always_comb begin
      state_n = state;
      accept  = 1'b0;
      case (state)
         IDLE: if (start && !busy) begin
            accept  = 1'b1;
            state_n = (dz_in || ovf_in) ? FIX : CALC;
         end
         CALC: if (cnt == LAST) state_n = FIX;
         FIX:  state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   // Divide-by-zero keeps |valA| in quo; re-applying the dividend sign gives
   // back valA as the remainder. INT_MIN/-1 needs no override: |INT_MIN| is
   // INT_MIN, the quotient sign is clear and the remainder is the cleared rem.
   always_comb begin
      q_res = dz ? '1 : (qsign ? -quo : quo);
      r_res = dz ? (rsign ? -quo : quo) : (rsign ? -rem : rem);
      res   = mod_r ? r_res : q_res;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy    <= 1'b0;
         done    <= 1'b0;
         valE    <= '0;
         alucc   <= '0;
         rem     <= '0;
         quo     <= '0;
         divisor <= '0;
         cnt     <= '0;
         qsign   <= 1'b0;
         rsign   <= 1'b0;
         mod_r   <= 1'b0;
         dz      <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (done) busy <= 1'b0;
         if (accept) begin
            busy    <= 1'b1;
            quo     <= abs_a;
            divisor <= abs_b;
            rem     <= '0;
            cnt     <= '0;
            qsign   <= a_neg ^ b_neg;
            rsign   <= a_neg;
            mod_r   <= ismod;
            dz      <= dz_in;
            ovf     <= ovf_in & ~dz_in;
         end
         if (state == CALC) begin
            rem <= rem_n;
            quo <= quo_n;
            cnt <= cnt + CNT_W'(1);
         end
         if (state == FIX) begin
            valE        <= res;
            alucc[CC_N] <= res[WIDTH-1];
            alucc[CC_Z] <= ~|res;
            alucc[CC_C] <= dz;
            alucc[CC_V] <= ovf & ~mod_r;
            done        <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_alu_div_seq.sv
// Directed-vector bench for alu_div_seq: latency, signed/unsigned results,
// special cases, start handshake rules and asynchronous reset.
module tb_alu_div_seq;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] valA = '0;
   logic [W-1:0] valB = '0;
   logic         issigned = 1'b0;
   logic         ismod = 1'b0;
   logic         busy, done;
   logic [W-1:0] valE;
   logic [3:0]   alucc;

   int errors = 0;
   int checks = 0;

   alu_div_seq #(.WIDTH(W), .CNT_W(6)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .valA     (valA),
      .valB     (valB),
      .issigned (issigned),
      .ismod    (ismod),
      .busy     (busy),
      .done     (done),
      .valE     (valE),
      .alucc    (alucc)
   );

   always #5 clk = ~clk;

   // Issue one operation and return the number of edges until done is seen,
   // counting the start-sampling edge as edge 1 (bounded at 100).
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic m, output int edges);
      @(negedge clk);
      valA = a; valB = b; issigned = s; ismod = m; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      edges = 1;
      while (!done && edges < 100) begin
         @(posedge clk); #1;
         edges++;
      end
      // Let busy drop before the next issue.
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #12;
      checks++;
      if ({busy, done} !== 2'b00 || valE !== '0 || alucc !== 4'h0) begin
         errors++;
         $display("FAIL reset_state: busy=%b done=%b valE=%h alucc=%b, want 0/0/0/0",
                  busy, done, valE, alucc);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_unsigned();
      int e;
      run_op(32'd100, 32'd7, 1'b0, 1'b0, e);
      checks++;
      if (e !== 34) begin errors++; $display("FAIL udiv_latency: got %0d edges, want 34", e); end
      checks++;
      if (valE !== 32'd14 || alucc !== 4'b0000) begin
         errors++; $display("FAIL udiv_100_7: valE=%h alucc=%b, want 0000000e/0000", valE, alucc);
      end
      run_op(32'd100, 32'd7, 1'b0, 1'b1, e);
      checks++;
      if (valE !== 32'd2 || alucc !== 4'b0000 || e !== 34) begin
         errors++; $display("FAIL umod_100_7: valE=%h alucc=%b edges=%0d, want 00000002/0000/34", valE, alucc, e);
      end
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b1, e);
      checks++;
      if (valE !== 32'd1 || alucc !== 4'b0000) begin
         errors++; $display("FAIL umod_large: valE=%h alucc=%b, want 00000001/0000", valE, alucc);
      end
   endtask

   task automatic test_signed();
      int e;
      run_op(-32'sd7, 32'd2, 1'b1, 1'b0, e);
      checks++;
      if (valE !== 32'hFFFF_FFFD || alucc !== 4'b1000 || e !== 34) begin
         errors++; $display("FAIL sdiv_m7_2: valE=%h alucc=%b edges=%0d, want fffffffd/1000/34", valE, alucc, e);
      end
      run_op(-32'sd7, 32'd2, 1'b1, 1'b1, e);
      checks++;
      if (valE !== 32'hFFFF_FFFF || alucc !== 4'b1000) begin
         errors++; $display("FAIL smod_m7_2: valE=%h alucc=%b, want ffffffff/1000", valE, alucc);
      end
      run_op(32'd7, -32'sd2, 1'b1, 1'b1, e);
      checks++;
      if (valE !== 32'd1 || alucc !== 4'b0000) begin
         errors++; $display("FAIL smod_7_m2: valE=%h alucc=%b, want 00000001/0000", valE, alucc);
      end
      run_op(32'd6, -32'sd7, 1'b1, 1'b0, e);
      checks++;
      if (valE !== 32'd0 || alucc !== 4'b0100) begin
         errors++; $display("FAIL sdiv_zero_quo: valE=%h alucc=%b, want 00000000/0100", valE, alucc);
      end
   endtask

   task automatic test_div_zero();
      int e;
      run_op(32'd5, 32'd0, 1'b0, 1'b0, e);
      checks++;
      if (valE !== 32'hFFFF_FFFF || alucc !== 4'b1010 || e !== 2) begin
         errors++; $display("FAIL dz_div: valE=%h alucc=%b edges=%0d, want ffffffff/1010/2", valE, alucc, e);
      end
      run_op(32'd5, 32'd0, 1'b0, 1'b1, e);
      checks++;
      if (valE !== 32'd5 || alucc !== 4'b0010 || e !== 2) begin
         errors++; $display("FAIL dz_mod: valE=%h alucc=%b edges=%0d, want 00000005/0010/2", valE, alucc, e);
      end
      run_op(-32'sd9, 32'd0, 1'b1, 1'b1, e);
      checks++;
      if (valE !== 32'hFFFF_FFF7 || alucc !== 4'b1010) begin
         errors++; $display("FAIL dz_smod_neg: valE=%h alucc=%b, want fffffff7/1010", valE, alucc);
      end
   endtask

   task automatic test_overflow();
      int e;
      run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, e);
      checks++;
      if (valE !== 32'h8000_0000 || alucc !== 4'b1001 || e !== 2) begin
         errors++; $display("FAIL ovf_div: valE=%h alucc=%b edges=%0d, want 80000000/1001/2", valE, alucc, e);
      end
      run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, e);
      checks++;
      if (valE !== 32'd0 || alucc !== 4'b0100 || e !== 2) begin
         errors++; $display("FAIL ovf_mod: valE=%h alucc=%b edges=%0d, want 00000000/0100/2", valE, alucc, e);
      end
      // Same operands unsigned are an ordinary divide: quotient 0.
      run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, e);
      checks++;
      if (valE !== 32'd0 || alucc !== 4'b0100 || e !== 34) begin
         errors++; $display("FAIL ovf_unsigned: valE=%h alucc=%b edges=%0d, want 00000000/0100/34", valE, alucc, e);
      end
   endtask

   task automatic test_extra_starts();
      int edges;
      int dones;
      logic [W-1:0] first;
      int e;
      @(negedge clk);
      valA = 32'd100; valB = 32'd7; issigned = 1'b0; ismod = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      edges = 1;
      repeat (8) begin @(posedge clk); #1; edges++; end
      // Pulse a competing request sampled at edge 10.
      @(negedge clk);
      valA = 32'd9; valB = 32'd3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      edges++;
      dones = 0;
      first = '0;
      while (dones == 0 && edges < 100) begin
         @(posedge clk); #1;
         edges++;
         if (done) begin dones++; first = valE; end
      end
      checks++;
      if (first !== 32'd14 || edges !== 34) begin
         errors++; $display("FAIL busy_start_ignored: valE=%h at edge %0d, want 0000000e at 34", first, edges);
      end
      // Still in the done cycle: a start here must be ignored.
      valA = 32'd50; valB = 32'd5; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (done) dones++;
      checks++;
      if (busy !== 1'b0 || dones !== 1) begin
         errors++; $display("FAIL done_cycle_start: busy=%b dones=%0d, want 0/1", busy, dones);
      end
      // Cycle after done: accepted.
      valA = 32'd9; valB = 32'd3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      e = 1;
      while (!done && e < 100) begin @(posedge clk); #1; e++; end
      checks++;
      if (valE !== 32'd3 || e !== 34) begin
         errors++; $display("FAIL start_after_done: valE=%h edges=%0d, want 00000003/34", valE, e);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      int e;
      int seen;
      @(negedge clk);
      valA = 32'd100; valB = 32'd7; issigned = 1'b0; ismod = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      checks++;
      if (busy !== 1'b0 || valE !== '0 || alucc !== 4'h0 || done !== 1'b0) begin
         errors++; $display("FAIL async_reset: busy=%b done=%b valE=%h alucc=%b, want 0/0/0/0",
                            busy, done, valE, alucc);
      end
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      repeat (40) begin @(posedge clk); #1; if (done || busy) seen++; end
      checks++;
      if (seen !== 0) begin
         errors++; $display("FAIL reset_abandons: %0d cycles with done/busy, want 0", seen);
      end
      run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, e);
      checks++;
      if (valE !== 32'hFFFF_FFFF || alucc !== 4'b1000 || e !== 34) begin
         errors++; $display("FAIL after_reset: valE=%h alucc=%b edges=%0d, want ffffffff/1000/34", valE, alucc, e);
      end
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_signed();
      test_div_zero();
      test_overflow();
      test_extra_starts();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
